// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide: shift-add multiply, restoring divide on magnitudes.
// Every operation takes 33 edges from the start edge to the registered result and RDY pulse.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam logic [5:0] LAST = 6'(WIDTH);

    state_t             state;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, rem, quo, dvs;
    logic               neg, div0, ovf;

    logic               start;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_signed;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH:0]     shifted, trial;

    // Both start pulses together is not a request at all.
    assign start = ctrl_mult ^ ctrl_div;
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        addend = '0;
        // The multiplier's sign bit carries negative weight, so the last partial product is subtracted.
        if (mplier[0]) addend = (cnt == LAST - 6'd1) ? -mcand : mcand;
        shifted    = {rem, quo[WIDTH-1]};
        trial      = shifted - {1'b0, dvs};
        quo_signed = neg ? -quo : quo;
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            neg            <= 1'b0;
            div0           <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                cnt <= '0;
                if (ctrl_mult) begin
                    state  <= MUL;
                    acc    <= '0;
                    mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                    mplier <= data_operandB;
                end else begin
                    state <= DIV;
                    rem   <= '0;
                    quo   <= mag_a;
                    dvs   <= mag_b;
                    neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div0  <= (data_operandB == '0);
                    ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
                end
            end else begin
                case (state)
                    MUL: begin
                        if (cnt == LAST) begin
                            data_result    <= acc[WIDTH-1:0];
                            data_exception <= (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else begin
                            acc    <= acc + addend;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                            cnt    <= cnt + 6'd1;
                        end
                    end
                    DIV: begin
                        if (cnt == LAST) begin
                            data_result    <= div0 ? '0 : quo_signed;
                            data_exception <= div0 | ovf;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else begin
                            if (!trial[WIDTH]) begin
                                rem <= trial[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= shifted[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b0};
                            end
                            cnt <= cnt + 6'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
